// File: rtl/prn_pkg.sv
// prn_pkg: shared definitions for the PRN despreader.
//   CODE_LEN  : default chips per PRN epoch
//   state_t   : despreader control states
//   chip_sign : BPSK mapping of a local code chip (0 -> +1, 1 -> -1)
package prn_pkg;

  localparam int unsigned CODE_LEN = 10230;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DUMP
  } state_t;

  function automatic logic signed [1:0] chip_sign(input logic chip);
    return chip ? -2'sd1 : 2'sd1;
  endfunction

endpackage

// File: rtl/prn_despreader_if.sv
// prn_despreader_if: chip stream in, epoch correlation out.
//   in_valid/in_ready/in_chip : received soft-chip handshake
//   corr_valid/corr_out/lock  : per-epoch correlation result
// Modports: master (chip source / result sink), slave (despreader).
interface prn_despreader_if #(
  parameter int SAMPLE_W = 4,
  parameter int ACC_W    = 18
);
  logic                       in_valid;
  logic                       in_ready;
  logic signed [SAMPLE_W-1:0] in_chip;
  logic                       corr_valid;
  logic signed [ACC_W-1:0]    corr_out;
  logic                       lock;

  modport master (output in_valid, in_chip,
                  input  in_ready, corr_valid, corr_out, lock);
  modport slave  (input  in_valid, in_chip,
                  output in_ready, corr_valid, corr_out, lock);
endinterface

// File: rtl/prn_code_sreg.sv
// prn_code_sreg: rotating local PRN code register.
//   clk, rst_n : clock, async active-low reset (register clears to zero)
//   code_in    : code word, bit 0 is the first chip
//   load       : capture code_in
//   rotate     : advance one chip; bit 0 wraps to the end
//   chip_out   : current local chip (bit 0)
module prn_code_sreg
  import prn_pkg::*;
#(
  parameter int unsigned LEN = prn_pkg::CODE_LEN
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [0:LEN-1] code_in,
  input  logic           load,
  input  logic           rotate,
  output logic           chip_out
);

  logic [0:LEN-1] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (load) begin
      sr <= code_in;
    end else if (rotate) begin
      sr <= {sr[1:LEN-1], sr[0]};
    end
  end

  assign chip_out = sr[0];

endmodule

// File: rtl/prn_despreader.sv
// prn_despreader: correlates a received soft-chip stream against a local
// PRN code, dumping the signed sum once per CODE_LEN-chip epoch.
//   clk, rst_n : clock, async active-low reset
//   code_in    : local code word (bit 0 = first chip), captured on code_load
//   code_load  : load code, restart epoch, enter RUN
//   abort      : return to IDLE (priority over code_load), keep last result
//   bus        : slave side of prn_despreader_if (chip in, result out)
//   chip_idx   : index of the next local chip
// Optional (macro PRN_DESPREAD_CHECK_EN): first_in/last_in compared against
// the head/tail 24 chips of code_in on code_load, registered into code_err.
module prn_despreader
  import prn_pkg::*;
#(
  parameter int unsigned CODE_LEN = prn_pkg::CODE_LEN,
  parameter int          SAMPLE_W = 4,
  parameter int          ACC_W    = 18,
  parameter int unsigned THRESH   = 20000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [0:CODE_LEN-1] code_in,
  input  logic                code_load,
  input  logic                abort,
  prn_despreader_if.slave     bus,
  output logic [13:0]         chip_idx
`ifdef PRN_DESPREAD_CHECK_EN
  ,
  input  logic [0:23]         first_in,
  input  logic [0:23]         last_in,
  output logic                code_err
`endif
);

  state_t state, state_nxt;

  logic                    accept, last_chip, dump_take, restart;
  logic                    chip_local, lock_now, lock_hold;
  logic signed [ACC_W-1:0] acc, sample_ext, term, corr_hold;
  logic        [ACC_W-1:0] mag;

  assign restart    = abort || code_load;
  assign accept     = (state == RUN) && bus.in_valid;
  assign last_chip  = accept && (chip_idx == 14'(CODE_LEN - 1));
  // A dump coinciding with code_load/abort is dropped entirely.
  assign dump_take  = (state == DUMP) && !restart;

  prn_code_sreg #(.LEN(CODE_LEN)) u_code (
    .clk      (clk),
    .rst_n    (rst_n),
    .code_in  (code_in),
    .load     (code_load && !abort),
    .rotate   (accept && !restart),
    .chip_out (chip_local)
  );

  assign sample_ext = {{(ACC_W-SAMPLE_W){bus.in_chip[SAMPLE_W-1]}}, bus.in_chip};
  assign term       = (chip_sign(chip_local) == -2'sd1) ? -sample_ext : sample_ext;
  assign mag        = acc[ACC_W-1] ? ACC_W'(-acc) : ACC_W'(acc);
  assign lock_now   = (mag >= ACC_W'(THRESH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = IDLE;
      RUN:     if (last_chip) state_nxt = DUMP;
      DUMP:    state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
    if (code_load) state_nxt = RUN;
    if (abort)     state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      chip_idx  <= '0;
      corr_hold <= '0;
      lock_hold <= 1'b0;
    end else if (restart) begin
      acc      <= '0;
      chip_idx <= '0;
    end else if (dump_take) begin
      acc       <= '0;
      corr_hold <= acc;
      lock_hold <= lock_now;
    end else if (accept) begin
      acc      <= acc + term;
      chip_idx <= last_chip ? '0 : chip_idx + 14'd1;
    end
  end

  // The DUMP cycle presents the live sum so the result is visible one cycle
  // after the last chip; the held copy carries it until the next dump.
  assign bus.in_ready   = (state == RUN);
  assign bus.corr_valid = dump_take;
  assign bus.corr_out   = dump_take ? acc : corr_hold;
  assign bus.lock       = dump_take ? lock_now : lock_hold;

`ifdef PRN_DESPREAD_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_err <= 1'b0;
    end else if (code_load) begin
      code_err <= (code_in[0:23] != first_in) ||
                  (code_in[CODE_LEN-24 +: 24] != last_in);
    end
  end
`endif

endmodule

// File: tb/tb_prn_despreader.sv
// Testbench for prn_despreader: directed epochs, expected dumps queued in a
// scoreboard and checked by an independent monitor on the falling edge.
module tb_prn_despreader;
  import prn_pkg::*;

  localparam int unsigned CL = 10230;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [0:CL-1] code_in;
  logic          code_load;
  logic          abort;
  logic [13:0]   chip_idx;
`ifdef PRN_DESPREAD_CHECK_EN
  logic [0:23]   first_in;
  logic [0:23]   last_in;
  logic          code_err;
`endif

  always #5 clk = ~clk;

  prn_despreader_if #(.SAMPLE_W(4), .ACC_W(18)) bus ();

  prn_despreader #(
    .CODE_LEN (CL),
    .SAMPLE_W (4),
    .ACC_W    (18),
    .THRESH   (20000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .code_in   (code_in),
    .code_load (code_load),
    .abort     (abort),
    .bus       (bus),
    .chip_idx  (chip_idx)
`ifdef PRN_DESPREAD_CHECK_EN
    ,
    .first_in  (first_in),
    .last_in   (last_in),
    .code_err  (code_err)
`endif
  );

  typedef struct {
    logic signed [17:0] corr;
    logic               lk;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   max_idx  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input longint c, input logic l);
    exp_t e;
    e.corr = 18'(c);
    e.lk   = l;
    sb.push_back(e);
  endtask

  // Monitor: pops one expectation per corr_valid pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && int'(chip_idx) > max_idx) max_idx = int'(chip_idx);
      if (bus.corr_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("corr_valid with empty scoreboard", bus.corr_valid, 0);
        end else begin
          e = sb.pop_front();
          check("corr_out", bus.corr_out, e.corr);
          check("lock", bus.lock, e.lk);
        end
      end
    end
  end

  task automatic load(input logic [0:CL-1] c);
    code_in   = c;
    code_load = 1'b1;
    @(posedge clk); #1;
    code_load = 1'b0;
  endtask

  task automatic feed(input int n, input logic signed [3:0] v, input bit toggle);
    int got = 0;
    int cyc = 0;
    bit acc;
    while (got < n) begin
      bus.in_valid = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.in_chip  = v;
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (acc) got++;
      cyc++;
      if (cyc > 4 * n + 16) begin
        check("feed timeout chips accepted", got, n);
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check("scoreboard drained", sb.size(), 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, " in_ready"},   bus.in_ready,   0);
    check({tag, " corr_valid"}, bus.corr_valid, 0);
    check({tag, " corr_out"},   bus.corr_out,   0);
    check({tag, " lock"},       bus.lock,       0);
    check({tag, " chip_idx"},   chip_idx,       0);
  endtask

  initial begin
    logic [0:CL-1] alt;

    rst_n        = 1'b0;
    code_load    = 1'b0;
    abort        = 1'b0;
    code_in      = '0;
    bus.in_valid = 1'b0;
    bus.in_chip  = '0;
`ifdef PRN_DESPREAD_CHECK_EN
    first_in = '0;
    last_in  = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
`ifdef PRN_DESPREAD_CHECK_EN
    check("reset code_err", code_err, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle in_ready", bus.in_ready, 0);

`ifdef PRN_DESPREAD_CHECK_EN
    first_in[7] = 1'b1;
    load('0);
    check("code_err head mismatch", code_err, 1);
    first_in = '0;
    load('0);
    check("code_err match", code_err, 0);
`endif

    // All-zero code, +7: 7 * 10230
    load('0);
    check("load chip_idx", chip_idx, 0);
    check("run in_ready", bus.in_ready, 1);
    push(71610, 1'b1);
    feed(CL, 4'sd7, 1'b0);
    drain();

    // All-one code, -8: two epochs without reload
    load('1);
    push(81840, 1'b1);
    push(81840, 1'b1);
    feed(2 * CL, -4'sd8, 1'b0);
    drain();

    // Alternating code, +7, random valid gaps: cancels to 0
    for (int i = 0; i < int'(CL); i++) alt[i] = i[0];
    load(alt);
    push(0, 1'b0);
    feed(CL, 4'sd7, 1'b1);
    drain();

    // Reload at chip 5000: pre-load chips must vanish
    load('0);
    feed(5000, 4'sd7, 1'b0);
    check("mid-epoch chip_idx", chip_idx, 5000);
    load('0);
    check("reload chip_idx", chip_idx, 0);
    push(10230, 1'b0);
    feed(CL, 4'sd1, 1'b0);
    drain();

    // Reset at chip 3000, then reload: all-one code, +3 -> -30690
    load('1);
    feed(3000, 4'sd5, 1'b0);
    check("pre-reset chip_idx", chip_idx, 3000);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("mid-epoch reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post-reset in_ready", bus.in_ready, 0);
    load('1);
    push(-30690, 1'b1);
    feed(CL, 4'sd3, 1'b0);
    drain();

    check("max chip_idx", max_idx, CL - 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prn_despreader.md
PRN_DESPREADER -- requirements
Module: prn_despreader

Interface
REQ-001 SHALL have parameter CODE_LEN, 10230, chips per PRN epoch.
REQ-002 SHALL have parameter SAMPLE_W, 4, signed two's-complement width of received soft chips.
REQ-003 SHALL have parameter ACC_W, 18, signed accumulator width; must hold ±CODE_LEN·2^(SAMPLE_W-1).
REQ-004 SHALL have parameter THRESH, 20000, unsigned lock threshold on the magnitude of the correlation.
REQ-005 SHALL have port clk, input, 1, single clock; every flop is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port code_in, input, [0:CODE_LEN-1], local PRN code word in generator bit order; bit 0 is the first chip.
REQ-008 SHALL have port code_load, input, 1, one-cycle strobe that captures code_in.
REQ-009 SHALL have port abort, input, 1, synchronous return to IDLE.
REQ-010 SHALL have port in_valid, input, 1, received chip valid.
REQ-011 SHALL have port in_ready, output, 1, block accepts a chip this cycle.
REQ-012 SHALL have port in_chip, input, SAMPLE_W, signed received chip sample.
REQ-013 SHALL have port corr_valid, output, 1, one-cycle pulse at the end of an epoch.
REQ-014 SHALL have port corr_out, output, ACC_W, signed epoch correlation, held until the next dump.
REQ-015 SHALL have port lock, output, 1, |corr_out| >= THRESH at the last dump.
REQ-016 SHALL have port chip_idx, output, 14, index of the next local chip to be used (0..CODE_LEN-1).

Function
REQ-017 SHALL implement the states IDLE, RUN and DUMP.
REQ-018 IDLE→RUN SHALL occur on code_load; in_ready SHALL be 0 in IDLE and DUMP and 1 in RUN.
REQ-019 A chip SHALL be accepted when in_valid && in_ready are both high in the same cycle; nothing SHALL change otherwise.
REQ-020 On each accepted chip, the accumulator SHALL add +in_chip if the local chip is 0, or -in_chip if it is 1 (BPSK mapping, sign-extended to ACC_W).
REQ-021 chip_idx SHALL increment on each accept and wrap from CODE_LEN-1 to 0; the local code SHALL rotate so the next epoch reuses the same code without a reload.
REQ-022 Accepting chip CODE_LEN-1 SHALL move RUN→DUMP; in DUMP, corr_out SHALL take the final sum, corr_valid=1, lock SHALL be updated, the accumulator SHALL clear, and the state SHALL return to RUN next cycle; the result SHALL appear one cycle after the last chip.
REQ-023 code_load in RUN or DUMP SHALL recapture the code, clear the accumulator, set chip_idx=0 and enter RUN; a dump in progress in the same cycle SHALL be discarded (corr_valid=0).
REQ-024 abort SHALL have priority over code_load: go to IDLE, clear the accumulator and chip_idx, and retain corr_out and lock.
REQ-025 The accumulator SHALL NOT saturate; the ACC_W bound guarantees no overflow.

Reset
REQ-026 While rst_n=0, the state SHALL be IDLE and in_ready, corr_valid, corr_out, lock and chip_idx SHALL all be 0; the code register SHALL be cleared to all zeros.
REQ-027 Asserting reset mid-epoch SHALL discard the partial sum; after release, a code_load is required.

Configuration
REQ-028 With PRN_DESPREAD_CHECK_EN defined, the block SHALL add inputs first_in[0:23] and last_in[0:23] and output code_err. code_err SHALL be registered on code_load and equal 1 if code_in[0:23]!=first_in or code_in[CODE_LEN-24:CODE_LEN-1]!=last_in. It SHALL be cleared by reset.
REQ-029 Without PRN_DESPREAD_CHECK_EN, those ports and that logic SHALL be absent.

Structure
REQ-030 Package prn_pkg SHALL hold CODE_LEN, the state enum, and the chip-to-sign helper function.
REQ-031 The rotating code register SHALL be a sub-module prn_code_sreg (load, rotate-on-accept, chip_out = current bit 0).

Verification
REQ-032 Code all 0, in_chip=+7 for all 10230 chips -> corr_out=71610, corr_valid one pulse, lock=1.
REQ-033 Code all 1, in_chip=-8 throughout -> corr_out=81840, lock=1; a second epoch with no reload -> identical result.
REQ-034 Code alternating 0/1, in_chip=+7 constant -> corr_out=0, lock=0; in_valid toggled 50% randomly -> same result, chip_idx never exceeds 10229.
REQ-035 code_load at chip 5000 mid-epoch -> no corr_valid, chip_idx=0, next dump reflects only post-load chips.
REQ-036 rst_n low at chip 3000, then release and code_load -> all outputs 0 during reset; the first dump after reload is correct.
REQ-037 With PRN_DESPREAD_CHECK_EN, load a code with first_in mismatched in bit 7 -> code_err=1 the cycle after code_load; matching values -> code_err=0.
